// File: rtl/pipe_control.sv
// Pipeline control: ID-stage decode, EX-stage branch/jump resolution against ALU flags,
// wrong-path squashing with a FLUSH counter, an EXEC two-step sequencer and hazard bubbles.
module pipe_control #(
  parameter int INSTR_W     = 16,
  parameter int FLUSH_SLOTS = 1,
  parameter bit EXEC_EN     = 1'b1,
  parameter int CNT_W       = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [INSTR_W-1:0] instr_in,
  input  logic [2:0]         flag,
  input  logic               hazard,
  output logic               write_en,
  output logic               mem_en,
  output logic [3:0]         alu_op,
  output logic [10:0]        sel,
  output logic               redirect,
  output logic [1:0]         state,
  output logic [CNT_W-1:0]   flush_cnt
);

  // Opcode map; 11xx are the control-flow instructions.
  localparam logic [3:0] OP_ADD = 4'h0, OP_SUB = 4'h1, OP_AND = 4'h2, OP_OR  = 4'h3,
                         OP_SLL = 4'h4, OP_SRL = 4'h5, OP_SRA = 4'h6, OP_RL  = 4'h7,
                         OP_LW  = 4'h8, OP_SW  = 4'h9, OP_LHB = 4'hA, OP_LLB = 4'hB,
                         OP_B   = 4'hC, OP_JAL = 4'hD, OP_JR  = 4'hE, OP_EXEC = 4'hF;

  // {sel[10:0], write_en, mem_en}
  localparam logic [12:0] DEC_NOP = 13'b1_1_000000_110_00;

  typedef enum logic [1:0] {S_RUN, S_FLUSH, S_EXEC_JMP, S_EXEC_RUN} state_e;

  state_e                            state_q, state_d;
  logic [1:0]                        fcnt_q, fcnt_d;
  logic [CNT_W-1:0]                  flush_cnt_q;
  logic [FLUSH_SLOTS:0][INSTR_W-1:0] hist_q;
  logic [FLUSH_SLOTS:0]              hist_vld_q;

  logic [3:0]  id_op, id_dst, ex_op, ex_cnd;
  logic        z, v, n, taken;
  logic [12:0] dec;
  logic [10:0] sel_c;
  logic        we_c, me_c, rd_c, squash;

  assign id_op  = instr_in[INSTR_W-1 -: 4];
  assign id_dst = instr_in[INSTR_W-5 -: 4];
  assign ex_op  = hist_q[0][INSTR_W-1 -: 4];
  assign ex_cnd = hist_q[0][INSTR_W-5 -: 4];
  assign {z, v, n} = flag;

  // Branch condition codes occupy 0..7; anything with cond[3] set never branches.
  always_comb begin
    taken = 1'b0;
    if (!ex_cnd[3]) begin
      case (ex_cnd[2:0])
        3'd0:    taken = !z;
        3'd1:    taken = z;
        3'd2:    taken = !z && !n;
        3'd3:    taken = n;
        3'd4:    taken = z || (!n && !z);
        3'd5:    taken = n || z;
        3'd6:    taken = v;
        default: taken = 1'b1;
      endcase
    end
  end

  always_comb begin
    dec = DEC_NOP;
    case (id_op)
      OP_ADD, OP_SUB, OP_AND, OP_OR: dec = 13'b1_1_000110_110_10;
      OP_SLL, OP_SRL, OP_SRA, OP_RL: dec = 13'b1_1_000010_110_10;
      OP_LW:   dec = 13'b1_1_011010_110_10;
      OP_SW:   dec = 13'b1_1_111101_110_01;
      OP_LHB:  dec = 13'b0_1_100010_110_10;
      OP_LLB:  dec = 13'b1_1_100000_110_10;
      OP_B:    dec = 13'b1_1_111111_110_00;
      OP_JAL:  dec = 13'b1_0_101111_110_10;
      OP_JR:   dec = 13'b1_0_111111_110_00;
      OP_EXEC: dec = EXEC_EN ? 13'b1_0_111111_110_00 : DEC_NOP;
      default: dec = DEC_NOP;
    endcase
    // R15 is the link register: only JAL may write it.
    if (id_dst == 4'hF && id_op != OP_JAL) dec[1] = 1'b0;

    sel_c   = dec[12:2];
    we_c    = dec[1];
    me_c    = dec[0];
    rd_c    = 1'b0;
    squash  = 1'b0;
    state_d = state_q;
    fcnt_d  = fcnt_q;

    if (hazard) begin
      sel_c[9] = 1'b0;
      we_c     = 1'b0;
      me_c     = 1'b0;
    end else begin
      case (state_q)
        S_RUN: begin
          if (hist_vld_q[0]) begin
            case (ex_op)
              OP_B:    if (taken) begin sel_c[2:0] = 3'b001; rd_c = 1'b1; end
              OP_JR:   begin sel_c[1:0] = 2'b11; sel_c[9] = 1'b1; rd_c = 1'b1; end
              OP_JAL:  begin sel_c[2:0] = 3'b101; rd_c = 1'b1; end
              OP_EXEC: rd_c = EXEC_EN;
              default: rd_c = 1'b0;
            endcase
          end
          if (rd_c) begin
            squash = 1'b1;
            if (ex_op == OP_EXEC) begin
              state_d = S_EXEC_JMP;
            end else if (FLUSH_SLOTS > 1) begin
              state_d = S_FLUSH;
              fcnt_d  = 2'(FLUSH_SLOTS - 1);
            end
          end
        end
        S_FLUSH: begin
          squash = 1'b1;
          fcnt_d = fcnt_q - 2'd1;
          if (fcnt_q <= 2'd1) state_d = S_RUN;
        end
        S_EXEC_JMP: begin
          // PC held while the EXEC target is fetched from the register file.
          squash     = 1'b1;
          sel_c[1:0] = 2'b11;
          sel_c[9]   = 1'b0;
          state_d    = S_EXEC_RUN;
        end
        S_EXEC_RUN: begin
          sel_c[0] = 1'b0;
          sel_c[9] = 1'b1;
          squash   = (id_op[3:2] == 2'b11);
          state_d  = S_RUN;
        end
        default: state_d = S_RUN;
      endcase
      if (squash) begin
        we_c = 1'b0;
        me_c = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= S_RUN;
      fcnt_q      <= '0;
      flush_cnt_q <= '0;
      hist_q      <= '0;
      hist_vld_q  <= '0;
    end else if (!hazard) begin
      state_q    <= state_d;
      fcnt_q     <= fcnt_d;
      hist_q     <= {hist_q[FLUSH_SLOTS-1:0], instr_in};
      hist_vld_q <= {hist_vld_q[FLUSH_SLOTS-1:0], !squash};
      if (squash && flush_cnt_q != {CNT_W{1'b1}})
        flush_cnt_q <= flush_cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
    end
  end

  // Outputs take their reset values the moment rst drops, without waiting for a clock.
  always_comb begin
    if (!rst) begin
      alu_op   = 4'h0;
      sel      = 11'b100_0000_0000;
      write_en = 1'b0;
      mem_en   = 1'b0;
      redirect = 1'b0;
    end else begin
      alu_op   = id_op;
      sel      = sel_c;
      write_en = we_c;
      mem_en   = me_c;
      redirect = rd_c;
    end
  end

  assign state     = state_q;
  assign flush_cnt = flush_cnt_q;

endmodule
